// File: rtl/sobel_frame_scheduler_if.sv
// Row-stream handshake bundle between the line DMA, the frame scheduler and the result consumer.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface sobel_frame_scheduler_if #(
    parameter int SIZE = 100
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SIZE*8-1:0]       in_row;
    logic                    out_valid;
    logic                    out_ready;
    logic [(SIZE-2)*8-1:0]   out_row;
    logic                    out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_last
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_last
    );
endinterface

// File: rtl/sobel_frame_scheduler.sv
// Frame sequencer for the Sobel row array: feeds rows, tags windows that yield valid results,
// flushes the array at frame end and buffers result rows in a small output FIFO.
module sobel_frame_scheduler #(
    parameter int SIZE       = 100,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROW_W-1:0]      cfg_rows,
    sobel_frame_scheduler_if.slave io,
    output logic [SIZE*8-1:0]     sobel_row,
    output logic                  sobel_en,
    input  logic [(SIZE-2)*8-1:0] sobel_res,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int ROW_BITS = SIZE * 8;
    localparam int RES_BITS = (SIZE - 2) * 8;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int FL_W     = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                state_reg;
    logic [ROW_W-1:0]      n_reg;
    logic [ROW_W-1:0]      row_cnt_reg;
    logic [FL_W-1:0]       flush_cnt_reg;
    logic [ROW_BITS-1:0]   sobel_row_reg;
    logic                  tag_reg [LAT];

    logic [RES_BITS:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      fifo_count_reg;

    logic pop;
    logic credit;
    logic accept;
    logic flush_adv;
    logic flush_last;
    logic tag_in;
    logic push;

    // A slot freed by this cycle's pop can be refilled on the same edge.
    assign pop         = (fifo_count_reg != '0) && io.out_ready;
    assign credit      = (fifo_count_reg - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
    assign io.in_ready = !rst && (state_reg != S_FLUSH) && credit;
    assign accept      = io.in_valid && io.in_ready;
    assign flush_adv   = !rst && (state_reg == S_FLUSH) && credit;
    assign flush_last  = (flush_cnt_reg == FL_W'(LAT - 1));
    assign sobel_en    = accept || flush_adv;
    assign tag_in      = accept && (state_reg == S_RUN);
    assign push        = sobel_en && tag_reg[LAT-1];
    assign frame_done  = flush_adv && flush_last;
    assign busy        = (state_reg != S_IDLE);
    assign sobel_row   = sobel_row_reg;

    assign io.out_valid              = (fifo_count_reg != '0);
    assign {io.out_last, io.out_row} = fifo_mem[rd_ptr_reg];

    // Tag pipeline mirrors the array depth; it only moves when the array moves.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst)
                        tag_reg[gi] <= 1'b0;
                    else if (sobel_en)
                        tag_reg[gi] <= tag_in;
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst)
                        tag_reg[gi] <= 1'b0;
                    else if (sobel_en)
                        tag_reg[gi] <= tag_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            n_reg         <= '0;
            row_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
            sobel_row_reg <= '0;
        end else begin
            if (accept)
                sobel_row_reg <= io.in_row;
            else if (flush_adv)
                sobel_row_reg <= '0;

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        n_reg       <= (cfg_rows < ROW_W'(3)) ? ROW_W'(3) : cfg_rows;
                        row_cnt_reg <= ROW_W'(1);
                        state_reg   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                        state_reg   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                        if (row_cnt_reg == n_reg - ROW_W'(1)) begin
                            state_reg     <= S_FLUSH;
                            flush_cnt_reg <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_adv) begin
                        flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
                        if (flush_last)
                            state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // The frame's final result always exits on the last flush advance.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {frame_done, sobel_res};
    end
endmodule
